// File: rtl/rr_chan_mux_pkg.sv
// Shared constants and types for the round-robin channel multiplexer.
// The packet-lock option is enabled by defining RR_CHAN_MUX_LOCK_EN.
package rr_chan_mux_pkg;

    localparam int DEFAULT_WIDTH    = 32;
    localparam int DEFAULT_CHANNELS = 16;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found after last_grant, wrapping around; last_grant itself is checked last.
module rr_arbiter #(
    parameter int CHANNELS = 16
) (
    input  logic [CHANNELS-1:0]         req,
    input  logic [$clog2(CHANNELS)-1:0] last_grant,
    output logic [CHANNELS-1:0]         gnt
);

    localparam int IDX_W = $clog2(CHANNELS);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = IDX_W'((int'(last_grant) + i) % CHANNELS);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_chan_mux.sv
// Round-robin N-to-1 channel multiplexer with a one-beat output register.
// Define RR_CHAN_MUX_LOCK_EN to add in_last and packet locking.
module rr_chan_mux
    import rr_chan_mux_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = DEFAULT_CHANNELS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS-1:0]           in_valid,
    input  logic [CHANNELS*WIDTH-1:0]     in_data,
`ifdef RR_CHAN_MUX_LOCK_EN
    input  logic [CHANNELS-1:0]           in_last,
`endif
    output logic [CHANNELS-1:0]           in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(CHANNELS)-1:0]   out_chan,
    input  logic                          out_ready,
    output logic [CHANNELS-1:0]           grant
);

    localparam int IDX_W = $clog2(CHANNELS);

    logic                rst_meta_n;
    logic                rst_sync_n;
    logic                load;
    logic                accept;
    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] arb_gnt;
    logic [IDX_W-1:0]    last_grant;
    logic [IDX_W-1:0]    sel_idx;
    logic [WIDTH-1:0]    sel_data;

    // Reset asserts at once but releases two clock edges later, so no
    // register leaves reset on an edge unrelated to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_n <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta_n <= 1'b1;
            rst_sync_n <= rst_meta_n;
        end
    end

    assign load = !out_valid || out_ready;

`ifdef RR_CHAN_MUX_LOCK_EN
    lock_state_e state_q;
    lock_state_e state_d;
    logic        accepted_last;

    // While locked, only the channel that opened the packet may compete.
    assign req           = (state_q == LOCKED) ? (in_valid & (CHANNELS'(1) << last_grant)) : in_valid;
    assign accepted_last = |(arb_gnt & in_last);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (accept && !accepted_last) state_d = LOCKED;
            LOCKED:  if (accept && accepted_last)  state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end
`else
    assign req = in_valid;
`endif

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arbiter (
        .req        (req),
        .last_grant (last_grant),
        .gnt        (arb_gnt)
    );

    assign accept   = load && rst_sync_n && (|arb_gnt);
    assign in_ready = (load && rst_sync_n) ? arb_gnt : '0;

    // One-hot to binary encode and AND-OR data select, both driven by the grant.
    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (arb_gnt[c]) begin
                sel_idx = sel_idx | IDX_W'(c);
            end
            sel_data = sel_data | (in_data[c*WIDTH +: WIDTH] & {WIDTH{arb_gnt[c]}});
        end
    end

    // Output register; last_grant only moves on an accepted beat.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            grant      <= '0;
            last_grant <= IDX_W'(CHANNELS - 1);
        end else if (load) begin
            out_valid <= accept;
            if (accept) begin
                out_data   <= sel_data;
                out_chan   <= sel_idx;
                grant      <= arb_gnt;
                last_grant <= sel_idx;
            end else begin
                grant      <= '0;
            end
        end
    end

endmodule

// File: doc/rr_chan_mux.md
RR_CHAN_MUX -- requirements
Module: rr_chan_mux

Interface
REQ-001 Parameter WIDTH, 32, data bits per channel, SHALL be at least 1.
REQ-002 Parameter CHANNELS, 16, number of input channels, SHALL be in the range 2..64.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  CHANNELS  per-channel request/valid.
REQ-006 in_data  input  CHANNELS x WIDTH  per-channel data, packed, channel 0 in the lowest slice.
REQ-007 in_ready  output  CHANNELS  one-hot or zero; a channel's beat is accepted when its in_valid and in_ready are both high.
REQ-008 out_valid  output  1  output register holds a beat.
REQ-009 out_data  output  WIDTH  registered selected data.
REQ-010 out_chan  output  clog2(CHANNELS)  binary index of the source channel of out_data.
REQ-011 out_ready  input  1  downstream accept.
REQ-012 grant  output  CHANNELS  one-hot registered source of the current beat; equals 1<<out_chan when out_valid is high, and zero otherwise.

Function
REQ-013 Output register load enable SHALL be: load = !out_valid | out_ready.
REQ-014 When load is high and any in_valid is high, the arbiter SHALL grant exactly one requester, round-robin, searching from (last_grant+1) mod CHANNELS upward with wrap-around.
REQ-015 in_ready SHALL be the combinational one-hot grant gated by load; it SHALL be all zero when load is low.
REQ-016 Data selection SHALL be a one-hot AND-OR mux of in_data by the grant; latency from acceptance to out_valid SHALL be exactly 1 cycle.
REQ-017 last_grant SHALL update only on an accepted beat.
REQ-018 With load high and no in_valid high, out_valid SHALL clear on the next edge, and last_grant SHALL hold.
REQ-019 With out_valid high and out_ready low, out_data, out_chan, grant and last_grant SHALL remain stable.
REQ-020 Full-throughput case: with out_ready held high, one beat SHALL be accepted and one beat emitted per cycle.
REQ-021 A single persistent requester SHALL win every cycle.
REQ-022 With all channels requesting, successive grants SHALL visit the channels in order k, k+1, ..., CHANNELS-1, 0, ... .

Reset
REQ-023 Asserting rst_n low SHALL immediately clear out_valid, grant, out_chan and out_data to 0, including mid-transfer; any in-flight beat is dropped.
REQ-024 Reset SHALL set last_grant to CHANNELS-1, so channel 0 has first priority after reset.
REQ-025 Reset SHALL return the lock state machine (REQ-027) to ARB.
REQ-026 Deassertion of rst_n SHALL be consumed synchronously to clk; no output may glitch on deassertion.

Configuration
REQ-027 Macro RR_CHAN_MUX_LOCK_EN, when defined, SHALL add the following:
- Input port in_last, CHANNELS bits wide.
- State machine with states ARB and LOCKED.
- ARB: an accepted beat whose in_last bit is 0 SHALL move the machine to LOCKED, holding the granted channel.
- LOCKED: only the held channel may be granted; an accepted beat with in_last=1 SHALL return the machine to ARB.
- LOCKED: other requesters SHALL stall even while the held channel is idle.
REQ-028 Without RR_CHAN_MUX_LOCK_EN, in_last SHALL be absent and arbitration SHALL be per beat.

Structure
REQ-029 Package rr_chan_mux_pkg SHALL hold the default WIDTH and CHANNELS constants and the lock-state enum type (ARB, LOCKED).
REQ-030 Sub-module rr_arbiter SHALL implement the combinational round-robin one-hot grant from requests plus last_grant, and SHALL be parametrised by CHANNELS.
REQ-031 All registers, the data mux and the lock FSM SHALL reside in rr_chan_mux.

Verification
REQ-032 Reset then in_valid=16'h0001, in_data[0]=32'hCAFE0000, out_ready=1 -> next cycle: out_valid=1, out_data=32'hCAFE0000, out_chan=0, grant=16'h0001.
REQ-033 in_valid=16'hFFFF held, out_ready=1 for 18 cycles -> out_chan sequence 0,1,...,15,0,1, with no bubbles.
REQ-034 in_valid=16'h8001, last_grant=0 -> channel 15 granted, then channel 0 (wrap-around).
REQ-035 out_ready=0 for 5 cycles while out_valid=1 -> out_data and out_chan stable, in_ready=0; on release, the next beat loads on the same edge as the pop.
REQ-036 rst_n pulsed low asynchronously mid-stream -> out_valid=0 immediately; the first grant after release is to the lowest requesting channel.
REQ-037 With RR_CHAN_MUX_LOCK_EN defined: channel 3 sends a 3-beat packet (in_last=0,0,1) while channel 4 requests -> out_chan=3,3,3,4.
